// File: rtl/gnrl_arb_mux_reg.sv
// Round-robin arbiter feeding a one-entry registered valid/ready output stage.
// Define GNRL_ARB_MUX_FIXED_PRIO_EN for fixed lowest-index-wins priority (no rotating pointer).
module gnrl_arb_mux_reg #(
   parameter int NUM_CH     = 16,
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = $clog2(NUM_CH)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_CH-1:0]            in_valid,
   output logic [NUM_CH-1:0]            in_ready,
   input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [DATA_WIDTH-1:0]        out_data,
   output logic [ID_WIDTH-1:0]          out_id
);

   logic [NUM_CH-1:0]     grant;
   logic [ID_WIDTH-1:0]   grant_idx;
   logic                  grant_any;
   logic                  load_en;
   logic                  xfer;
   logic [DATA_WIDTH-1:0] sel_data;

   logic                  out_valid_q, out_valid_d;
   logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
   logic [ID_WIDTH-1:0]   out_id_q, out_id_d;

   function automatic logic [ID_WIDTH-1:0] first_set(input logic [NUM_CH-1:0] v);
      first_set = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (v[i]) first_set = ID_WIDTH'(i);
      end
   endfunction

   assign grant_any = |in_valid;

`ifdef GNRL_ARB_MUX_FIXED_PRIO_EN
   assign grant_idx = first_set(in_valid);
`else
   logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
   logic [NUM_CH-1:0]   hi_mask;
   logic [NUM_CH-1:0]   hi_valid;

   // Channels at or above the pointer win first; otherwise wrap to the lowest valid one.
   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_mask
      assign hi_mask[gi] = (ID_WIDTH'(gi) >= rr_ptr_q);
   end

   assign hi_valid  = in_valid & hi_mask;
   assign grant_idx = (|hi_valid) ? first_set(hi_valid) : first_set(in_valid);

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (xfer) begin
         rr_ptr_d = (grant_idx == ID_WIDTH'(NUM_CH - 1)) ? '0 : grant_idx + ID_WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_q <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
      end
   end
`endif

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_grant
      assign grant[gi] = grant_any & (grant_idx == ID_WIDTH'(gi));
   end

   assign load_en  = ~out_valid_q | out_ready;
   assign in_ready = grant & {NUM_CH{load_en & ~rst}};
   assign xfer     = grant_any & load_en & ~rst;

   // AND-OR mux on the one-hot grant.
   always_comb begin
      sel_data = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (grant[i]) sel_data = sel_data | in_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_id_d    = out_id_q;
      if (xfer) begin
         out_valid_d = 1'b1;
         out_data_d  = sel_data;
         out_id_d    = grant_idx;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_id_q    <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_id_q    <= out_id_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_id    = out_id_q;

endmodule

// File: tb/tb_gnrl_arb_mux_reg.sv
// Scoreboard bench for gnrl_arb_mux_reg with NUM_CH=5 (non-power-of-two wrap).
// Reference model: scan channels from the pointer modulo NUM_CH; output stage as an occupancy bit.
module tb_gnrl_arb_mux_reg;
   localparam int N  = 5;
   localparam int DW = 32;
   localparam int IW = $clog2(N);

   typedef struct packed {
      logic [DW-1:0] data;
      logic [IW-1:0] id;
   } item_t;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [N-1:0]    in_valid = '1;
   logic [N-1:0]    in_ready;
   logic [N*DW-1:0] in_data = '0;
   logic            out_valid;
   logic            out_ready = 1'b0;
   logic [DW-1:0]   out_data;
   logic [IW-1:0]   out_id;

   item_t exp_q[$];
   int    n_checks = 0;
   int    n_fail   = 0;
   bit    pushed_now = 1'b0;
   int    model_ptr  = 0;
   bit    model_full = 1'b0;

   gnrl_arb_mux_reg #(.NUM_CH(N), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_id(out_id)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One cycle: drive inputs at negedge, predict the arbiter decision, check in_ready.
   task automatic step(input logic r, input logic [N-1:0] v, input logic ord, input bit rnd);
      int           win;
      bit           le;
      logic [N-1:0] exp_rdy;
      item_t        it;
      @(negedge clk);
      rst       = r;
      in_valid  = v;
      out_ready = ord;
      for (int i = 0; i < N; i++)
         in_data[i*DW +: DW] = rnd ? DW'($urandom) : (32'hA5A5_0000 | DW'(i));
      #1;
      exp_rdy    = '0;
      pushed_now = 1'b0;
      if (r) begin
         exp_q.delete();
         model_ptr  = 0;
         model_full = 1'b0;
      end else begin
         le  = !model_full || ord;
         win = -1;
         for (int k = 0; k < N; k++) begin
            if (win < 0 && v[(model_ptr + k) % N]) win = (model_ptr + k) % N;
         end
         if (le && win >= 0) begin
            exp_rdy[win] = 1'b1;
            it.data = in_data[win*DW +: DW];
            it.id   = IW'(win);
            exp_q.push_back(it);
            pushed_now = 1'b1;
            model_full = 1'b1;
`ifndef GNRL_ARB_MUX_FIXED_PRIO_EN
            model_ptr  = (win + 1) % N;
`endif
         end else if (model_full && ord) begin
            model_full = 1'b0;
         end
      end
      $display("cycle rst=%0b in_valid=%b out_ready=%0b in_ready=%b", r, v, ord, in_ready);
      check("in_ready", 64'(in_ready), 64'(exp_rdy));
   endtask

   // Monitor: compares the presented output against the oldest expected entry.
   initial begin
      bit rst_prev;
      int in_flight;
      rst_prev = 1'b1;
      forever begin
         @(negedge clk);
         #2;
         if (rst_prev) begin
            check("reset_out_valid", 64'(out_valid), 64'(0));
            check("reset_out_data", 64'(out_data), 64'(0));
            check("reset_out_id", 64'(out_id), 64'(0));
         end
         if (!rst) begin
            in_flight = exp_q.size() - (pushed_now ? 1 : 0);
            check("out_valid", 64'(out_valid), 64'(in_flight > 0));
            if (out_valid && in_flight > 0) begin
               check("out_data", 64'(out_data), 64'(exp_q[0].data));
               check("out_id", 64'(out_id), 64'(exp_q[0].id));
               if (out_ready) begin
                  $display("xfer id=%0d data=%h", out_id, out_data);
                  void'(exp_q.pop_front());
               end
            end
         end
         rst_prev = rst;
      end
   end

   initial begin
      // Reset held with everything valid.
      repeat (3) step(1'b1, '1, 1'b1, 1'b0);
      // Round-robin fairness, first grant to ch0.
      repeat (10) step(1'b0, '1, 1'b1, 1'b0);
      // Stall holding ch2, then ch3 next.
      step(1'b0, 5'b00100, 1'b1, 1'b0);
      repeat (5) step(1'b0, 5'b01010, 1'b0, 1'b0);
      step(1'b0, 5'b01010, 1'b1, 1'b0);
      step(1'b0, 5'b00000, 1'b1, 1'b0);
      // Pointer skip and wrap.
      step(1'b0, 5'b01000, 1'b1, 1'b0);
      step(1'b0, 5'b10010, 1'b1, 1'b0);
      step(1'b0, 5'b10010, 1'b1, 1'b0);
      step(1'b0, 5'b00001, 1'b1, 1'b0);
      step(1'b0, 5'b00011, 1'b1, 1'b0);
      // Reset during a stall.
      step(1'b0, 5'b00100, 1'b1, 1'b1);
      step(1'b0, 5'b11111, 1'b0, 1'b1);
      step(1'b1, 5'b11111, 1'b0, 1'b1);
      step(1'b0, 5'b11111, 1'b1, 1'b1);
      // Two contenders continuously valid.
      repeat (6) step(1'b0, 5'b01001, 1'b1, 1'b1);
      // Single active channel under random back-pressure.
      repeat (8) step(1'b0, 5'b00010, 1'($urandom_range(0, 1)), 1'b1);
      // Random traffic with occasional reset.
      repeat (400)
         step(1'($urandom_range(0, 49) == 0), N'($urandom), 1'($urandom_range(0, 3) != 0), 1'b1);
      // Drain.
      repeat (3) step(1'b0, '0, 1'b1, 1'b1);
      @(negedge clk);
      #3;
      check("drain_empty", 64'(exp_q.size()), 64'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
